// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-way round-robin / fixed-priority arbiter.
package arb_pkg;

  localparam int unsigned ARB_MAX_N = 32;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } arb_state_e;

  // Index of the set bit in a one-hot (or all-zero) vector; all-zero maps to 0.
  function automatic logic [4:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] onehot);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (onehot[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational picker: first eligible bit searching upward from i_base, wrapping at N-1.
module arb_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_eligible,
  input  logic [IDW-1:0] i_base,
  output logic [N-1:0]   o_winner,
  output logic           o_found
);

  always_comb begin
    logic        w_found;
    int unsigned w_idx;
    o_winner = '0;
    w_found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = int'(i_base) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_eligible[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
    o_found = w_found;
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter with runtime round-robin / fixed priority, grant locking and a bounded hold time.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           mode_rr,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  localparam int unsigned   HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

  arb_state_e     r_state, w_state_nxt;
  logic [N-1:0]   r_gnt, w_gnt_nxt;
  logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [HW-1:0]  r_hold, w_hold_nxt;

  logic [N-1:0]   w_eligible;
  logic [N-1:0]   w_winner;
  logic           w_found;
  logic [IDW-1:0] w_base;
  logic [IDW-1:0] w_win_id;
  logic           w_owner_req;
  logic           w_hold_done;
  logic           w_take_new;

  // The current owner is never eligible; in IDLE r_gnt is zero so all requests compete.
  assign w_eligible  = req & ~r_gnt;
  assign w_base      = mode_rr ? r_ptr : '0;
  assign w_owner_req = |(req & r_gnt);
  assign w_hold_done = (r_hold == HoldLast);
  assign w_win_id    = IDW'(onehot_to_idx(ARB_MAX_N'(w_winner)));

  arb_pick #(
    .N  (N),
    .IDW(IDW)
  ) u_pick (
    .i_eligible(w_eligible),
    .i_base    (w_base),
    .o_winner  (w_winner),
    .o_found   (w_found)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_ptr_nxt    = r_ptr;
    w_hold_nxt   = r_hold;
    w_take_new   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_found) w_take_new = 1'b1;
      end
      GRANT: begin
        if (!w_owner_req || w_hold_done) begin
          if (w_found) begin
            w_take_new = 1'b1;
          end else if (!w_owner_req) begin
            w_state_nxt  = IDLE;
            w_gnt_nxt    = '0;
            w_gnt_id_nxt = '0;
            w_hold_nxt   = '0;
          end else begin
            // Hold limit reached but nobody else is waiting: owner keeps it, counter wraps.
            w_hold_nxt = '0;
          end
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
        w_hold_nxt   = '0;
      end
    endcase

    if (w_take_new) begin
      w_state_nxt  = GRANT;
      w_gnt_nxt    = w_winner;
      w_gnt_id_nxt = w_win_id;
      w_hold_nxt   = '0;
      w_ptr_nxt    = (w_win_id == IDW'(N - 1)) ? '0 : w_win_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_ptr    <= w_ptr_nxt;
      r_hold   <= w_hold_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;
  assign gnt_id    = r_gnt_id;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=1) share stimulus; each step selects which to check.
module tb_rr_priority_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_rr;
  logic [3:0] req;

  logic [3:0] gnt4, gnt1;
  logic       v4, v1;
  logic [1:0] id4, id1;

  always #5 clk = ~clk;

  rr_priority_arbiter #(
    .N       (4),
    .MAX_HOLD(4)
  ) dut4 (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .mode_rr  (mode_rr),
    .gnt      (gnt4),
    .gnt_valid(v4),
    .gnt_id   (id4)
  );

  rr_priority_arbiter #(
    .N       (4),
    .MAX_HOLD(1)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .mode_rr  (mode_rr),
    .gnt      (gnt1),
    .gnt_valid(v1),
    .gnt_id   (id1)
  );

  // sel: 0 = check dut4 only, 1 = dut1 only, 2 = both
  typedef struct {
    logic [3:0] gnt;
    int         sel;
    int         tnum;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tnum    = 0;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic cmp(input string who, input logic [3:0] g, input logic v, input logic [1:0] id,
                     input exp_t e);
    logic       ev;
    logic [1:0] eid;
    ev  = |e.gnt;
    eid = idx_of(e.gnt);
    n_tests++;
    if (g !== e.gnt || v !== ev || id !== eid) begin
      n_fail++;
      $display("FAIL test%0d %s: gnt=%b valid=%b id=%0d, expected gnt=%b valid=%b id=%0d",
               e.tnum, who, g, v, id, e.gnt, ev, eid);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.sel != 1) cmp("dut4", gnt4, v4, id4, mon_e);
      if (mon_e.sel != 0) cmp("dut1", gnt1, v1, id1, mon_e);
    end
  end

  task automatic step(input logic rst, input logic [3:0] r, input logic m, input int sel,
                      input logic [3:0] eg);
    exp_t e;
    reset   = rst;
    req     = r;
    mode_rr = m;
    @(posedge clk);
    e.gnt  = eg;
    e.sel  = sel;
    e.tnum = tnum;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] t3_exp [13];
    logic [3:0] t4_exp [5];
    t3_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
               4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    t4_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset   = 1'b1;
    req     = 4'b0000;
    mode_rr = 1'b0;
    @(negedge clk);

    // 1: reset dominates requests; first grant one edge after release
    tnum = 1;
    step(1'b1, 4'b1111, 1'b0, 2, 4'b0000);
    step(1'b1, 4'b1111, 1'b0, 2, 4'b0000);
    step(1'b0, 4'b1111, 1'b0, 2, 4'b0001);

    // 2: fixed priority release and return to idle
    tnum = 2;
    step(1'b0, 4'b1010, 1'b0, 0, 4'b0010);
    step(1'b0, 4'b1000, 1'b0, 0, 4'b1000);
    step(1'b0, 4'b0000, 1'b0, 0, 4'b0000);

    // 3: fixed priority with hold bound of 4
    tnum = 3;
    for (int i = 0; i < 13; i++) step(1'b0, 4'b1111, 1'b0, 0, t3_exp[i]);

    // 4: round-robin rotation with hold bound of 1
    tnum = 4;
    step(1'b1, 4'b0000, 1'b1, 2, 4'b0000);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, 1'b1, 1, t4_exp[i]);

    // 5: round-robin release with pointer wrap
    tnum = 5;
    step(1'b1, 4'b0000, 1'b1, 2, 4'b0000);
    step(1'b0, 4'b0100, 1'b1, 0, 4'b0100);
    step(1'b0, 4'b1001, 1'b1, 0, 4'b1000);
    step(1'b0, 4'b0001, 1'b1, 0, 4'b0001);

    // 6: locked owner across hold wrap, mid-grant reset in cycle 6
    tnum = 6;
    step(1'b1, 4'b0000, 1'b0, 2, 4'b0000);
    for (int c = 1; c <= 10; c++) begin
      step((c == 6), 4'b0100, 1'b0, 0, (c == 6) ? 4'b0000 : 4'b0100);
    end

    reset = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
